imem_port_arbiter: RTL and testbench

//  Owns the single port of the word-addressed instruction memory and shares it between
//  the fetch stage (reads) and the program loader (writes). After reset it holds fetch
//  in BOOT until the loader signals completion, then gives fetch priority. A wait

---
 rtl/imem_port_arbiter_if.sv | 36 +++
 rtl/imem_port_arbiter.sv | 108 ++++++++++
 tb/tb_imem_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Signal bundle between the instruction-memory port arbiter, its two requesters
// (fetch and program loader) and the single-port instruction memory.
interface imem_port_arbiter_if;
  // Handshake: a requester holds *_req with stable address/data. The access
  // completes in any cycle where req is high and the arbiter accepts it
  // (fetch: ~fetch_stall, loader: ld_grant). Otherwise the requester retries.
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_grant;
  logic        ld_start;
  logic        ld_done;
  logic        boot_done;
  logic        addr_err;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_start, ld_done, mem_rdata,
    output fetch_stall, fetch_valid, fetch_data, ld_grant, boot_done, addr_err,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_start, ld_done, mem_rdata,
    input  fetch_stall, fetch_valid, fetch_data, ld_grant, boot_done, addr_err,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch reads and loader writes:
// the loader owns it in BOOT, fetch has priority in RUN with a starvation guard.
module imem_port_arbiter #(
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 8,
  localparam int WW      = $clog2(MAX_WAIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_port_arbiter_if.master bus,
  output logic                dbg_state_o,
  output logic [WW-1:0]       dbg_wait_cnt_o
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [31:0]   fetch_data_q, fetch_data_d;
  logic          addr_err_q, addr_err_d;

  logic          force_slot;
  logic          ld_grant;
  logic          fetch_stall;
  logic          fetch_gnt;
  logic [29:0]   fetch_idx;
  logic [29:0]   ld_idx;
  logic          fetch_in_range;
  logic          ld_in_range;
  logic          unused_addr_lsbs;

  assign fetch_idx        = bus.fetch_addr[31:2];
  assign ld_idx           = bus.ld_addr[31:2];
  assign fetch_in_range   = (fetch_idx < 30'(DEPTH));
  assign ld_in_range      = (ld_idx < 30'(DEPTH));
  assign unused_addr_lsbs = ^{bus.fetch_addr[1:0], bus.ld_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      wait_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      addr_err_q    <= addr_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ld_grant      = 1'b0;
    fetch_stall   = 1'b0;
    force_slot    = (state_q == ST_RUN) && (wait_cnt_q == WW'(MAX_WAIT));

    // Grants are gated by rst_n so a reset cycle never commits an access.
    case (state_q)
      ST_BOOT: begin
        ld_grant    = rst_n & bus.ld_req;
        fetch_stall = bus.fetch_req;
        if (bus.ld_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        ld_grant    = rst_n & bus.ld_req & (~bus.fetch_req | force_slot);
        fetch_stall = bus.fetch_req & force_slot & bus.ld_req;
        if (bus.ld_start) state_d = ST_BOOT;
      end
      default: state_d = ST_BOOT;
    endcase

    fetch_gnt = rst_n & bus.fetch_req & ~fetch_stall;

    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || !bus.ld_req || ld_grant) begin
      wait_cnt_d = '0;
    end else if ((state_q == ST_RUN) && (wait_cnt_q != WW'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Out-of-range fetches return a NOP instead of whatever the memory drives.
    fetch_valid_d = fetch_gnt;
    fetch_data_d  = fetch_data_q;
    if (fetch_gnt) fetch_data_d = fetch_in_range ? bus.mem_rdata : 32'h0000_0000;
    addr_err_d    = (fetch_gnt & ~fetch_in_range) | (ld_grant & ~ld_in_range);
  end

  assign bus.ld_grant    = ld_grant;
  assign bus.fetch_stall = fetch_stall;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.boot_done   = (state_q == ST_RUN);
  assign bus.mem_we      = ld_grant & ld_in_range;
  assign bus.mem_addr    = ld_grant ? ld_idx : fetch_idx;
  assign bus.mem_wdata   = bus.ld_wdata;

  assign dbg_state_o     = state_q;
  assign dbg_wait_cnt_o  = wait_cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter against a behavioural model
// of the boot/run port-sharing rules and the instruction memory contents.
module tb_imem_port_arbiter;
  localparam int DEPTH    = 64;
  localparam int MAX_WAIT = 8;
  localparam int WW       = $clog2(MAX_WAIT + 1);

  logic          clk;
  logic          rst_n;
  logic          dbg_state;
  logic [WW-1:0] dbg_wait_cnt;
  logic          mem_init;
  logic [31:0]   tb_mem [DEPTH];

  imem_port_arbiter_if bus ();

  imem_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.master),
    .dbg_state_o    (dbg_state),
    .dbg_wait_cnt_o (dbg_wait_cnt)
  );

  // clock / memory behind the port
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i * 7);
  endfunction

  assign bus.mem_rdata = (bus.mem_addr < 30'(DEPTH)) ? tb_mem[bus.mem_addr[5:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  // reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  bit          m_run;
  int          m_wait;
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_err;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: inputs already driven after a falling edge; check, then advance model.
  task automatic run_cycle();
    bit          frc, e_ldg, e_stall, e_fg, e_we, f_oor, l_oor, n_run;
    int          f_idx, l_idx;
    #1;
    f_idx   = int'(bus.fetch_addr / 4);
    l_idx   = int'(bus.ld_addr / 4);
    f_oor   = (f_idx >= DEPTH);
    l_oor   = (l_idx >= DEPTH);
    frc     = m_run && (m_wait == MAX_WAIT);
    e_stall = m_run ? (bus.fetch_req && frc && bus.ld_req) : bus.fetch_req;
    e_ldg   = rst_n && bus.ld_req && (!m_run || !bus.fetch_req || frc);
    e_fg    = rst_n && bus.fetch_req && !e_stall;
    e_we    = e_ldg && !l_oor;

    chk("ld_grant", 32'(bus.ld_grant), 32'(e_ldg));
    if (rst_n) chk("fetch_stall", 32'(bus.fetch_stall), 32'(e_stall));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), e_ldg ? 32'(l_idx) : 32'(f_idx));
    if (e_we) chk("mem_wdata", bus.mem_wdata, bus.ld_wdata);
    chk("boot_done", 32'(bus.boot_done), 32'(m_run));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
    chk("fetch_data", bus.fetch_data, m_data);
    chk("addr_err", 32'(bus.addr_err), 32'(m_err));
    chk("wait_cnt", 32'(dbg_wait_cnt), 32'(m_wait));

    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_wait = 0; m_valid = 0; m_data = '0; m_err = 0;
      exp_q.delete();
    end else begin
      n_run = m_run ? !bus.ld_start : bus.ld_done;
      if (!bus.ld_req || e_ldg || (n_run != m_run)) m_wait = 0;
      else if (m_run && m_wait < MAX_WAIT) m_wait++;
      m_run = n_run;
      if (e_fg) exp_q.push_back(f_oor ? 32'h0 : ref_mem[f_idx]);
      if (e_we) ref_mem[l_idx] = bus.ld_wdata;
      m_valid = e_fg;
      m_err   = (e_fg && f_oor) || (e_ldg && l_oor);
      if (m_valid) m_data = exp_q.pop_front();
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input logic [31:0] la,
                       input logic [31:0] lw, input bit ls, input bit ldn);
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.ld_req     = lr;
    bus.ld_addr    = la;
    bus.ld_wdata   = lw;
    bus.ld_start   = ls;
    bus.ld_done    = ldn;
    run_cycle();
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.ld_req = 0; bus.ld_addr = '0;
    bus.ld_wdata = '0; bus.ld_start = 0; bus.ld_done = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_run = 0; m_wait = 0; m_valid = 0; m_data = '0; m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    run_cycle();
    rst_n = 1'b1;

    // held in BOOT: fetch stalls indefinitely
    repeat (6) drive(1, 32'h0, 0, 32'h0, 32'h0, 0, 0);

    // load two words, finish boot, fetch one back
    drive(0, 32'h0, 1, 32'h0, 32'h2008_0005, 0, 0);
    drive(0, 32'h0, 1, 32'h4, 32'h2009_000C, 0, 1);
    drive(1, 32'h4, 0, 32'h0, 32'h0, 0, 0);
    chk("t2_fetch_data", bus.fetch_data, 32'h2009_000C);
    idle();

    // continuous contention: forced loader slot every MAX_WAIT+1 cycles
    repeat (3 * (MAX_WAIT + 1)) drive(1, 32'(4 * $urandom_range(0, DEPTH - 1)), 1,
                                      32'(4 * $urandom_range(0, DEPTH - 1)), $urandom, 0, 0);
    idle();

    // out-of-range fetch and write
    drive(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
    idle();
    drive(0, 32'h0, 1, 32'h100, 32'h1234_5678, 0, 0);
    idle();

    // ld_start wins over same-cycle ld_done, then fetch stalls in BOOT
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 1);
    drive(1, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 0, 1);

    // reset while a loader write would be granted
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
    rst_n = 1'b0;
    drive(0, 32'h0, 1, 32'h10, 32'hCAFE_F00D, 0, 0);
    rst_n = 1'b1;
    drive(1, 32'h10, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    drive(1, 32'h10, 0, 32'h0, 32'h0, 0, 0);
    idle();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 7, 32'(4 * $urandom_range(0, DEPTH + 6) + $urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 32'(4 * $urandom_range(0, DEPTH + 6) + $urandom_range(0, 3)),
            $urandom, $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0);
    end
    rst_n = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
